// File: rtl/detector_seq_pkg.sv
// Shared definitions for the detector sequencer: state encoding and default word width.
package detector_seq_pkg;
  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLR   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_CLR   = CLR,
    S_SHIFT = SHIFT,
    S_DONE  = DONE
  } state_t;
endpackage

// File: rtl/detector_seq_datapath.sv
// Shift register, detector-output capture, bit counter and ones counter for the sequencer.
module detector_seq_datapath
  import detector_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_bit,
  output logic             o_msb,
  output logic             o_last_bit,
  output logic [WIDTH-1:0] o_result,
  output logic [CNT_W-1:0] o_ones_cnt
);
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ones;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_ones   <= '0;
    end else if (i_load) begin
      r_sr     <= i_data;
      r_result <= '0;
      r_cnt    <= '0;
      r_ones   <= '0;
    end else if (i_shift) begin
      // Captured bit is the detector's Mealy response to the bit currently on o_msb.
      r_result <= {r_result[WIDTH-2:0], i_bit};
      r_ones   <= r_ones + CNT_W'(i_bit);
      r_sr     <= {r_sr[WIDTH-2:0], 1'b0};
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign o_msb      = r_sr[WIDTH-1];
  assign o_last_bit = (r_cnt == CNT_W'(WIDTH - 1));
  assign o_result   = r_result;
  assign o_ones_cnt = r_ones;
endmodule

// File: rtl/detector_sequencer.sv
// Serializes a word MSB-first into a sequence-detector FSM and captures its per-bit output.
module detector_sequencer
  import detector_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             fsm_rst,
  output logic             fsm_in,
  input  logic             fsm_out
);
  state_t r_state;
  logic   w_load, w_shift, w_msb, w_last_bit;

  assign w_load  = (r_state == S_IDLE) && start;
  assign w_shift = (r_state == S_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_CLR;
        S_CLR:   r_state <= S_SHIFT;
        S_SHIFT: if (w_last_bit) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake and detector controls decode state only; start never reaches them combinationally.
  assign busy    = (r_state == S_CLR) || (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);
  assign fsm_in  = w_shift & w_msb;
  assign fsm_rst = rst | (r_state == S_CLR);

  detector_seq_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (data_in),
    .i_bit      (fsm_out),
    .o_msb      (w_msb),
    .o_last_bit (w_last_bit),
    .o_result   (result),
    .o_ones_cnt (ones_cnt)
  );
endmodule
